alpu_icon_rd_arb: RTL and testbench

// Round-robin arbiter/sequencer sharing one ALPU cache's single interconnect read port (icon_r0*)

---
 rtl/alpu_icon_rd_arb.sv | 202 ++++++++++++++++++++
 tb/tb_alpu_icon_rd_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpu_icon_rd_arb.sv
// alpu_icon_rd_arb: round-robin sequencer that shares one alpu_cache interconnect
// read port (icon_r0*) between NUM_REQ foreign execution units. A grant latches
// the requester's address, probes the cache TX buffer until a hit, the retry
// limit, or the requester gives up, returns the data, and then rotates priority.
// Optional build macro ALPU_RARB_STATS_EN adds saturating hit/miss counters
// (stat_hits, stat_misses).
module alpu_icon_rd_arb #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_RETRY = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_W-1:0]                rsp_data,
    output logic [ADDR_W-1:0]                icon_r0addr,
    output logic                             icon_r0ready,
    input  logic                             icon_r0valid,
    input  logic [DATA_W-1:0]                icon_r0data
`ifdef ALPU_RARB_STATS_EN
    ,
    output logic [15:0]                      stat_hits,
    output logic [15:0]                      stat_misses
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RTY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [RTY_W-1:0] RETRY_LAST = RTY_W'(MAX_RETRY - 1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PROBE = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [PTR_W-1:0]  rr_ptr_r;
    logic [PTR_W-1:0]  gnt_idx_r;
    logic [RTY_W-1:0]  retry_cnt_r;

    logic              pick_found_s;
    logic [PTR_W-1:0]  pick_idx_s;
    logic [PTR_W-1:0]  scan_s;
    logic              granted_valid_s;
    logic              do_grant_s;
    logic              do_hit_s;
    logic              do_release_s;
    logic              do_retry_s;

    // Advance a requester index by one, wrapping NUM_REQ-1 back to 0.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Saturating 16-bit increment used by the statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Round-robin pick: first requesting index starting at rr_ptr and wrapping.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = {PTR_W{1'b0}};
        scan_s       = rr_ptr_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found_s && req_valid[scan_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = scan_s;
            end else begin
                pick_found_s = pick_found_s;
            end
            scan_s = wrap_inc(scan_s);
        end
    end

    // The granted requester must still be asserting its request for a probe to count.
    assign granted_valid_s = req_valid[gnt_idx_r];
    assign icon_r0ready    = (state_r == ST_PROBE) && granted_valid_s;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-cycle action decode; abandon beats hit beats miss.
    always_comb begin
        state_next_s = state_r;
        do_grant_s   = 1'b0;
        do_hit_s     = 1'b0;
        do_release_s = 1'b0;
        do_retry_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    do_grant_s   = 1'b1;
                    state_next_s = ST_PROBE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PROBE: begin
                if (!granted_valid_s) begin
                    do_release_s = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (icon_r0valid) begin
                    do_hit_s     = 1'b1;
                    do_release_s = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (retry_cnt_r == RETRY_LAST) begin
                    do_release_s = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    do_retry_s   = 1'b1;
                    state_next_s = ST_PROBE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping: one-hot grant, granted index, latched address, retry count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt         <= {NUM_REQ{1'b0}};
            gnt_idx_r   <= {PTR_W{1'b0}};
            icon_r0addr <= {ADDR_W{1'b0}};
            retry_cnt_r <= {RTY_W{1'b0}};
        end else if (do_grant_s) begin
            gnt         <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
            gnt_idx_r   <= pick_idx_s;
            icon_r0addr <= req_addr[pick_idx_s];
            retry_cnt_r <= {RTY_W{1'b0}};
        end else if (do_release_s) begin
            gnt         <= {NUM_REQ{1'b0}};
        end else if (do_retry_s) begin
            retry_cnt_r <= retry_cnt_r + RTY_W'(1);
        end else begin
            retry_cnt_r <= retry_cnt_r;
        end
    end

    // Priority rotates past whoever just held the grant, however it ended.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= {PTR_W{1'b0}};
        end else if (do_release_s) begin
            rr_ptr_r <= wrap_inc(gnt_idx_r);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Response: one-cycle pulse to the granted requester; data held between hits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= {NUM_REQ{1'b0}};
            rsp_data  <= {DATA_W{1'b0}};
        end else if (do_hit_s) begin
            rsp_valid <= gnt;
            rsp_data  <= icon_r0data;
        end else begin
            rsp_valid <= {NUM_REQ{1'b0}};
        end
    end

`ifdef ALPU_RARB_STATS_EN
    // Saturating probe statistics; abandoned probes (ready low) count as neither.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_hits   <= 16'h0000;
            stat_misses <= 16'h0000;
        end else if (icon_r0ready && icon_r0valid) begin
            stat_hits   <= sat_inc16(stat_hits);
        end else if (icon_r0ready) begin
            stat_misses <= sat_inc16(stat_misses);
        end else begin
            stat_hits   <= stat_hits;
        end
    end
`endif

endmodule

// File: tb/tb_alpu_icon_rd_arb.sv
// Directed bench for alpu_icon_rd_arb with a response scoreboard. Build with
// +define+ALPU_RARB_STATS_EN to also exercise the statistics counters.
module tb_alpu_icon_rd_arb;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [3:0]         req_valid;
    logic [3:0][15:0]   req_addr;
    logic [3:0]         gnt;
    logic [3:0]         rsp_valid;
    logic [31:0]        rsp_data;
    logic [15:0]        icon_r0addr;
    logic               icon_r0ready;
    logic               icon_r0valid;
    logic [31:0]        icon_r0data;
`ifdef ALPU_RARB_STATS_EN
    logic [15:0]        stat_hits;
    logic [15:0]        stat_misses;
`endif

    // Cache TX buffer model: hits when enabled, data either fixed or address-derived.
    logic               hit_en;
    logic               use_fixed;
    logic [31:0]        fixed_data;
    assign icon_r0valid = hit_en & icon_r0ready;
    assign icon_r0data  = use_fixed ? fixed_data : {16'hC0DE, icon_r0addr};

    typedef struct {
        logic [3:0]  oh;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alpu_icon_rd_arb #(.NUM_REQ(4), .MAX_RETRY(4), .ADDR_W(16), .DATA_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .icon_r0addr  (icon_r0addr),
        .icon_r0ready (icon_r0ready),
        .icon_r0valid (icon_r0valid),
        .icon_r0data  (icon_r0data)
`ifdef ALPU_RARB_STATS_EN
        ,
        .stat_hits    (stat_hits),
        .stat_misses  (stat_misses)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] oh, input logic [31:0] data);
        exp_t e;
        e.oh   = oh;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    // One requester, first-probe hit: grant in cycle 1, response in cycle 2.
    task automatic hit_txn(input int idx, input logic [31:0] data);
        logic [3:0] oh;
        oh        = 4'b0001 << idx;
        hit_en    = 1'b1;
        req_valid = oh;
        push_exp(oh, data);
        step();
        chk("hit_gnt", {60'd0, gnt}, {60'd0, oh});
        chk("hit_addr", {48'd0, icon_r0addr}, {48'd0, req_addr[idx]});
        chk("hit_ready", {63'd0, icon_r0ready}, 64'd1);
        step();
        chk("hit_rsp_valid", {60'd0, rsp_valid}, {60'd0, oh});
        chk("hit_rsp_data", {32'd0, rsp_data}, {32'd0, data});
        chk("hit_idle_gnt", {60'd0, gnt}, 64'd0);
        chk("hit_idle_ready", {63'd0, icon_r0ready}, 64'd0);
        req_valid = 4'b0000;
        step();
    endtask

    // Scoreboard monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && rsp_valid !== 4'b0000) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL rsp_unexpected: observed rsp_valid %0h expected none", rsp_valid);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rsp_valid", {60'd0, rsp_valid}, {60'd0, e.oh});
                chk("sb_rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
            end
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        req_valid  = 4'b0000;
        hit_en     = 1'b0;
        use_fixed  = 1'b0;
        fixed_data = 32'h0000_0000;
        for (int i = 0; i < 4; i++) req_addr[i] = 16'h0100 + 16'(i);
        #1;
        // Reset values while reset is asserted.
        chk("rst_gnt", {60'd0, gnt}, 64'd0);
        chk("rst_rsp_valid", {60'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        chk("rst_ready", {63'd0, icon_r0ready}, 64'd0);
        chk("rst_addr", {48'd0, icon_r0addr}, 64'd0);
        do_reset();

        // Test 1: single request, fixed hit data.
        req_addr[1] = 16'h0012;
        use_fixed   = 1'b1;
        fixed_data  = 32'hDEADBEEF;
        hit_txn(1, 32'hDEADBEEF);
        use_fixed   = 1'b0;
        req_addr[1] = 16'h0101;

        // Test 2: all four held, always hit -> grants 0,1,2,3,0 on odd cycles.
        do_reset();
        hit_en    = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) push_exp(4'b0001 << (k % 4), {16'hC0DE, 16'h0100 + 16'(k % 4)});
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c % 2 == 1) chk("rr_gnt", {60'd0, gnt}, {60'd0, 4'b0001 << (((c - 1) / 2) % 4)});
            else            chk("rr_gap_gnt", {60'd0, gnt}, 64'd0);
        end
        req_valid = 4'b0000;
        step();
        chk("rr_end_gnt", {60'd0, gnt}, 64'd0);

        // Test 3: always miss -> 4 probes, IDLE at 5, re-grant at 6 (req1 wins if set).
        for (int sc = 0; sc < 2; sc++) begin
            do_reset();
            hit_en    = 1'b0;
            req_valid = (sc == 1) ? 4'b0011 : 4'b0001;
            for (int c = 1; c <= 6; c++) begin
                step();
                if (c <= 4) begin
                    chk("miss_gnt", {60'd0, gnt}, 64'd1);
                    chk("miss_ready", {63'd0, icon_r0ready}, 64'd1);
                end else if (c == 5) begin
                    chk("miss_release_gnt", {60'd0, gnt}, 64'd0);
                    chk("miss_release_ready", {63'd0, icon_r0ready}, 64'd0);
                end else begin
                    chk("miss_regrant", {60'd0, gnt}, (sc == 1) ? 64'd2 : 64'd1);
                end
            end
            req_valid = 4'b0000;
            step();
            step();
        end

        // Test 4: req2 dropped during its 2nd probe -> abandon, rr_ptr moves to 3.
        do_reset();
        hit_en    = 1'b0;
        req_valid = 4'b0100;
        step();
        chk("drop_gnt", {60'd0, gnt}, 64'h4);
        step();
        req_valid = 4'b0000;
        #1;
        chk("drop_ready_low", {63'd0, icon_r0ready}, 64'd0);
        step();
        chk("drop_idle_gnt", {60'd0, gnt}, 64'd0);
        chk("drop_no_rsp", {60'd0, rsp_valid}, 64'd0);
        hit_en    = 1'b1;
        req_valid = 4'b1111;
        push_exp(4'b1000, {16'hC0DE, 16'h0103});
        step();
        chk("drop_rr_ptr3", {60'd0, gnt}, 64'h8);
        step();
        chk("drop_next_rsp", {60'd0, rsp_valid}, 64'h8);
        req_valid = 4'b0000;
        step();

        // Test 5: reset mid-probe clears outputs at once and rr_ptr returns to 0.
        hit_txn(1, {16'hC0DE, 16'h0101});
        hit_en    = 1'b0;
        req_valid = 4'b0100;
        step();
        chk("rstmid_gnt", {60'd0, gnt}, 64'h4);
        reset_n = 1'b0;
        #1;
        chk("rstmid_gnt_clr", {60'd0, gnt}, 64'd0);
        chk("rstmid_ready_clr", {63'd0, icon_r0ready}, 64'd0);
        chk("rstmid_rsp_clr", {60'd0, rsp_valid}, 64'd0);
        req_valid = 4'b0110;
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("rstmid_first_gnt", {60'd0, gnt}, 64'h2);
        req_valid = 4'b0000;
        step();
        step();

`ifdef ALPU_RARB_STATS_EN
        // Test 6: 3 hits and 5 misses, then hit counter saturation.
        do_reset();
        chk("stat_rst_hits", {48'd0, stat_hits}, 64'd0);
        for (int k = 0; k < 3; k++) hit_txn(k, {16'hC0DE, 16'h0100 + 16'(k)});
        hit_en    = 1'b0;
        req_valid = 4'b0001;
        for (int c = 1; c <= 7; c++) step();
        req_valid = 4'b0000;
        step();
        step();
        chk("stat_hits", {48'd0, stat_hits}, 64'd3);
        chk("stat_misses", {48'd0, stat_misses}, 64'd5);
        force dut.stat_hits = 16'hFFFE;
        #1;
        release dut.stat_hits;
        hit_txn(0, {16'hC0DE, 16'h0100});
        hit_txn(1, {16'hC0DE, 16'h0101});
        chk("stat_hits_sat", {48'd0, stat_hits}, 64'hFFFF);
        chk("stat_misses_hold", {48'd0, stat_misses}, 64'd5);
`endif

        step();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
